// File: rtl/noc_pkg.sv
// Shared types and header-layout helpers for the NoC transmit interface.
// Header fields are packed LSB first: dest_x, dest_y, src_x, src_y, len.
package noc_pkg;

    localparam int FIELD_W   = 8;
    localparam int HDR_MAX_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD
    } pkt_state_t;

    typedef struct packed {
        logic [FIELD_W-1:0] len;
        logic [FIELD_W-1:0] src_y;
        logic [FIELD_W-1:0] src_x;
        logic [FIELD_W-1:0] dest_y;
        logic [FIELD_W-1:0] dest_x;
    } header_t;

    function automatic int hdr_off_dest_x();
        return 0;
    endfunction

    function automatic int hdr_off_dest_y(int xw);
        return xw;
    endfunction

    function automatic int hdr_off_src_x(int xw, int yw);
        return xw + yw;
    endfunction

    function automatic int hdr_off_src_y(int xw, int yw);
        return 2 * xw + yw;
    endfunction

    function automatic int hdr_off_len(int xw, int yw);
        return 2 * xw + 2 * yw;
    endfunction

    function automatic int hdr_width(int xw, int yw, int lw);
        return 2 * xw + 2 * yw + lw;
    endfunction

    // Field values wider than their slot are masked so they cannot spill into a neighbour.
    function automatic logic [HDR_MAX_W-1:0] hdr_field(logic [FIELD_W-1:0] v, int w, int off);
        logic [HDR_MAX_W-1:0] mask;
        mask = (HDR_MAX_W'(1) << w) - HDR_MAX_W'(1);
        return (HDR_MAX_W'(v) & mask) << off;
    endfunction

    function automatic logic [HDR_MAX_W-1:0] pack_header(header_t h, int xw, int yw, int lw);
        return hdr_field(h.dest_x, xw, hdr_off_dest_x())
             | hdr_field(h.dest_y, yw, hdr_off_dest_y(xw))
             | hdr_field(h.src_x,  xw, hdr_off_src_x(xw, yw))
             | hdr_field(h.src_y,  yw, hdr_off_src_y(xw, yw))
             | hdr_field(h.len,    lw, hdr_off_len(xw, yw));
    endfunction

endpackage

// File: rtl/noc_out_reg.sv
// AXI-Stream output register toward the router; accepts a new flit whenever
// it is empty or its current flit is being taken in the same cycle.
module noc_out_reg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_last,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_last,
    output logic                  o_can_load
);

    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
            r_last  <= i_last;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data     = r_data;
    assign o_valid    = r_valid;
    assign o_last     = r_last;
    assign o_can_load = !r_valid || i_ready;

endmodule

// File: rtl/noc_packetizer.sv
// Transmit network interface: turns a send request plus payload stream into
// one header flit followed by len payload flits on router channel 0.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | ready for a request; header loaded directly if out reg free
// ST_HEADER  | request latched, waiting for the out reg to take the header
// ST_PAYLOAD | forwarding payload beats, r_remaining counts down to 0
module noc_packetizer
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH              = 32,
    parameter int MAX_ROUTERS_X           = 4,
    parameter int MAX_ROUTERS_Y           = 4,
    parameter int ROUTER_X                = 0,
    parameter int ROUTER_Y                = 0,
    parameter int MAXIMUM_PACKAGES_NUMBER = 5
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         req_valid,
    output logic                                         req_ready,
    input  logic [$clog2(MAX_ROUTERS_X)-1:0]             req_dest_x,
    input  logic [$clog2(MAX_ROUTERS_Y)-1:0]             req_dest_y,
    input  logic [$clog2(MAXIMUM_PACKAGES_NUMBER+1)-1:0] req_len,
    input  logic [DATA_WIDTH-1:0]                        s_tdata,
    input  logic                                         s_tvalid,
    output logic                                         s_tready,
    output logic [DATA_WIDTH-1:0]                        m_tdata,
    output logic                                         m_tvalid,
    input  logic                                         m_tready,
    output logic                                         m_tlast,
    output logic                                         busy,
    output logic                                         err_len
);

    localparam int X_W   = $clog2(MAX_ROUTERS_X);
    localparam int Y_W   = $clog2(MAX_ROUTERS_Y);
    localparam int LEN_W = $clog2(MAXIMUM_PACKAGES_NUMBER + 1);
    localparam int HDR_W = hdr_width(X_W, Y_W, LEN_W);

    if (DATA_WIDTH < HDR_W) begin : g_width_check
        $error("noc_packetizer: DATA_WIDTH %0d cannot hold a %0d-bit header", DATA_WIDTH, HDR_W);
    end

    pkt_state_t       r_state;
    logic [X_W-1:0]   r_dest_x;
    logic [Y_W-1:0]   r_dest_y;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_remaining;
    logic             r_err_len;

    logic                  w_can_load;
    logic                  w_req_fire;
    logic                  w_len_ok;
    logic                  w_hdr_load;
    logic                  w_beat_fire;
    logic                  w_load;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic                  w_load_last;
    logic [LEN_W-1:0]      w_hdr_len;
    header_t               w_hdr;

    assign w_req_fire  = req_valid && (r_state == ST_IDLE);
    assign w_len_ok    = req_len <= LEN_W'(MAXIMUM_PACKAGES_NUMBER);
    assign w_hdr_load  = (w_req_fire && w_len_ok && w_can_load)
                      || ((r_state == ST_HEADER) && w_can_load);
    assign w_beat_fire = (r_state == ST_PAYLOAD) && w_can_load && s_tvalid;
    assign w_load      = w_hdr_load || w_beat_fire;

    // In IDLE the header is built straight from the request so it lands one cycle after accept.
    always_comb begin
        w_hdr       = '0;
        w_hdr.src_x = FIELD_W'(ROUTER_X);
        w_hdr.src_y = FIELD_W'(ROUTER_Y);
        if (r_state == ST_IDLE) begin
            w_hdr.dest_x = FIELD_W'(req_dest_x);
            w_hdr.dest_y = FIELD_W'(req_dest_y);
            w_hdr_len    = req_len;
        end else begin
            w_hdr.dest_x = FIELD_W'(r_dest_x);
            w_hdr.dest_y = FIELD_W'(r_dest_y);
            w_hdr_len    = r_len;
        end
        w_hdr.len = FIELD_W'(w_hdr_len);
    end

    assign w_load_data = w_hdr_load ? DATA_WIDTH'(pack_header(w_hdr, X_W, Y_W, LEN_W)) : s_tdata;
    assign w_load_last = w_hdr_load ? (w_hdr_len == '0) : (r_remaining == LEN_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_dest_x    <= '0;
            r_dest_y    <= '0;
            r_len       <= '0;
            r_remaining <= '0;
            r_err_len   <= 1'b0;
        end else begin
            r_err_len <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (!w_len_ok) begin
                            r_err_len <= 1'b1;
                        end else begin
                            r_dest_x    <= req_dest_x;
                            r_dest_y    <= req_dest_y;
                            r_len       <= req_len;
                            r_remaining <= req_len;
                            if (!w_can_load) begin
                                r_state <= ST_HEADER;
                            end else if (req_len != '0) begin
                                r_state <= ST_PAYLOAD;
                            end
                        end
                    end
                end
                ST_HEADER: begin
                    if (w_can_load) begin
                        r_state <= (r_len == '0) ? ST_IDLE : ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (w_beat_fire) begin
                        r_remaining <= r_remaining - LEN_W'(1);
                        if (r_remaining == LEN_W'(1)) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    noc_out_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_data    (w_load_data),
        .i_last    (w_load_last),
        .i_ready   (m_tready),
        .o_data    (m_tdata),
        .o_valid   (m_tvalid),
        .o_last    (m_tlast),
        .o_can_load(w_can_load)
    );

    assign req_ready = (r_state == ST_IDLE);
    assign s_tready  = (r_state == ST_PAYLOAD) && w_can_load;
    assign busy      = (r_state != ST_IDLE) || m_tvalid;
    assign err_len   = r_err_len;

endmodule

// File: tb/tb_noc_packetizer.sv
// Directed and randomised bench for noc_packetizer on a 4x4 mesh at router (1,2):
// hand-computed header values plus a flit scoreboard fed by a channel monitor.
module tb_noc_packetizer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_dest_x;
    logic [1:0]  req_dest_y;
    logic [2:0]  req_len;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        busy;
    logic        err_len;

    logic m_tready_dir = 1'b1;
    logic rnd_en       = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    logic [32:0] got_q[$];
    logic [32:0] exp_q[$];

    logic        r_prev_stall = 1'b0;
    logic [33:0] r_prev_out   = '0;

    always #5 clk = ~clk;

    noc_packetizer #(
        .DATA_WIDTH             (32),
        .MAX_ROUTERS_X          (4),
        .MAX_ROUTERS_Y          (4),
        .ROUTER_X               (1),
        .ROUTER_Y               (2),
        .MAXIMUM_PACKAGES_NUMBER(5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_dest_x(req_dest_x),
        .req_dest_y(req_dest_y),
        .req_len   (req_len),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tlast   (m_tlast),
        .busy      (busy),
        .err_len   (err_len)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Header layout written out by hand: len | src_y=2 | src_x=1 | dest_y | dest_x.
    function automatic logic [31:0] hdr(input logic [1:0] dx, input logic [1:0] dy, input logic [2:0] len);
        return {21'd0, len, 2'd2, 2'd1, dy, dx};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic cmp_queues(input string tag);
        chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk(tag, 64'(got_q[i]), 64'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic drain(input string tag);
        int w;
        w = 0;
        smp();
        while (busy && w < 100) begin
            tick();
            smp();
            w++;
        end
        chk({tag, "_drain"}, 64'(busy), 64'(0));
    endtask

    // Sole driver of m_tready: directed level or random stalls.
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            m_tready = rnd_en ? ($urandom_range(0, 2) != 0) : m_tready_dir;
        end
    end

    always @(posedge clk) begin
        if (!rst && r_prev_stall)
            chk("hold_stable", 64'({m_tvalid, m_tlast, m_tdata}), 64'(r_prev_out));
        r_prev_stall <= !rst && m_tvalid && !m_tready;
        r_prev_out   <= {m_tvalid, m_tlast, m_tdata};
        if (!rst && m_tvalid && m_tready) got_q.push_back({m_tlast, m_tdata});
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        logic [1:0]  dx, dy;
        logic [2:0]  len;
        logic [31:0] word;

        req_valid  = 1'b0;
        req_dest_x = '0;
        req_dest_y = '0;
        req_len    = '0;
        s_tvalid   = 1'b0;
        s_tdata    = '0;

        repeat (2) tick();
        rst = 1'b0;
        smp();
        chk("rst_tvalid", 64'(m_tvalid), 64'(0));
        chk("rst_tlast", 64'(m_tlast), 64'(0));
        chk("rst_tdata", 64'(m_tdata), 64'(0));
        chk("rst_err", 64'(err_len), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(1));
        chk("rst_s_tready", 64'(s_tready), 64'(0));

        // Header encoding: dest (3,0) len 2
        tick(); req_valid = 1'b1; req_dest_x = 2'd3; req_dest_y = 2'd0; req_len = 3'd2;
        smp();  chk("t1_req_ready", 64'(req_ready), 64'(1));
        tick(); req_valid = 1'b0; s_tvalid = 1'b1; s_tdata = 32'hA;
        smp();  chk("t1_hdr_valid", 64'(m_tvalid), 64'(1));
                chk("t1_hdr_data", 64'(m_tdata), 64'h293);
                chk("t1_hdr_last", 64'(m_tlast), 64'(0));
                chk("t1_s_tready", 64'(s_tready), 64'(1));
                chk("t1_req_busy", 64'(req_ready), 64'(0));
        tick(); s_tdata = 32'hB;
        smp();  chk("t1_p0_data", 64'(m_tdata), 64'hA);
                chk("t1_p0_last", 64'(m_tlast), 64'(0));
        tick(); s_tvalid = 1'b0;
        smp();  chk("t1_p1_data", 64'(m_tdata), 64'hB);
                chk("t1_p1_last", 64'(m_tlast), 64'(1));
        tick();
        smp();  chk("t1_idle_valid", 64'(m_tvalid), 64'(0));
                chk("t1_idle_busy", 64'(busy), 64'(0));
        exp_q.push_back({1'b0, 32'h293});
        exp_q.push_back({1'b0, 32'hA});
        exp_q.push_back({1'b1, 32'hB});
        cmp_queues("t1_flits");

        // Zero-length packet, then a len-1 request back to back
        tick(); req_valid = 1'b1; req_dest_x = 2'd0; req_dest_y = 2'd3; req_len = 3'd0;
        smp();  chk("t2_req_ready", 64'(req_ready), 64'(1));
        tick(); req_dest_x = 2'd1; req_dest_y = 2'd1; req_len = 3'd1;
        smp();  chk("t2_hdr_data", 64'(m_tdata), 64'h9C);
                chk("t2_hdr_last", 64'(m_tlast), 64'(1));
                chk("t2_s_tready", 64'(s_tready), 64'(0));
                chk("t2_next_ready", 64'(req_ready), 64'(1));
        tick(); req_valid = 1'b0; s_tvalid = 1'b1; s_tdata = 32'h55;
        smp();  chk("t2_hdr2_data", 64'(m_tdata), 64'h195);
                chk("t2_hdr2_last", 64'(m_tlast), 64'(0));
        tick(); s_tvalid = 1'b0;
        smp();  chk("t2_p0_data", 64'(m_tdata), 64'h55);
                chk("t2_p0_last", 64'(m_tlast), 64'(1));
        tick();
        smp();  chk("t2_idle_valid", 64'(m_tvalid), 64'(0));
        exp_q.push_back({1'b1, 32'h9C});
        exp_q.push_back({1'b0, 32'h195});
        exp_q.push_back({1'b1, 32'h55});
        cmp_queues("t2_flits");

        // Illegal length
        tick(); req_valid = 1'b1; req_dest_x = 2'd2; req_dest_y = 2'd2; req_len = 3'd6;
        smp();  chk("t4_req_ready", 64'(req_ready), 64'(1));
        tick(); req_valid = 1'b0;
        smp();  chk("t4_err_pulse", 64'(err_len), 64'(1));
                chk("t4_no_valid", 64'(m_tvalid), 64'(0));
                chk("t4_req_ready2", 64'(req_ready), 64'(1));
                chk("t4_busy", 64'(busy), 64'(0));
        tick();
        smp();  chk("t4_err_clear", 64'(err_len), 64'(0));
                chk("t4_no_valid2", 64'(m_tvalid), 64'(0));
        cmp_queues("t4_flits");

        // Back-pressure on the 2nd payload flit of a len-5 packet to (2,1)
        tick(); req_valid = 1'b1; req_dest_x = 2'd2; req_dest_y = 2'd1; req_len = 3'd5;
        smp();
        tick(); req_valid = 1'b0; s_tvalid = 1'b1; s_tdata = 32'hC000_0000;
        smp();  chk("t3_hdr_data", 64'(m_tdata), 64'h596);
        tick(); s_tdata = 32'hC000_0001;
        smp();  chk("t3_p0_data", 64'(m_tdata), 64'hC000_0000);
        tick(); s_tdata = 32'hC000_0002; m_tready_dir = 1'b0;
        smp();  chk("t3_stall_data", 64'(m_tdata), 64'hC000_0001);
                chk("t3_stall_s_tready", 64'(s_tready), 64'(0));
        for (int i = 0; i < 2; i++) begin
            tick();
            smp();
            chk("t3_stall_data", 64'(m_tdata), 64'hC000_0001);
            chk("t3_stall_valid", 64'(m_tvalid), 64'(1));
            chk("t3_stall_s_tready", 64'(s_tready), 64'(0));
        end
        tick(); m_tready_dir = 1'b1;
        smp();  chk("t3_release_data", 64'(m_tdata), 64'hC000_0001);
                chk("t3_release_s_tready", 64'(s_tready), 64'(1));
        tick(); s_tdata = 32'hC000_0003;
        smp();  chk("t3_p2_data", 64'(m_tdata), 64'hC000_0002);
        tick(); s_tdata = 32'hC000_0004;
        smp();  chk("t3_p3_data", 64'(m_tdata), 64'hC000_0003);
        tick(); s_tvalid = 1'b0;
        smp();  chk("t3_p4_data", 64'(m_tdata), 64'hC000_0004);
                chk("t3_p4_last", 64'(m_tlast), 64'(1));
        tick();
        smp();  chk("t3_idle_valid", 64'(m_tvalid), 64'(0));
        exp_q.push_back({1'b0, 32'h596});
        for (int i = 0; i < 5; i++) exp_q.push_back({(i == 4), 32'hC000_0000 + 32'(i)});
        cmp_queues("t3_flits");

        // Reset during the 3rd payload beat, then a fresh len-1 packet to (0,1)
        tick(); req_valid = 1'b1; req_dest_x = 2'd3; req_dest_y = 2'd3; req_len = 3'd5;
        smp();
        tick(); req_valid = 1'b0; s_tvalid = 1'b1; s_tdata = 32'hE000_0000;
        smp();  chk("t5_hdr_data", 64'(m_tdata), 64'h59F);
        tick(); s_tdata = 32'hE000_0001;
        smp();  chk("t5_p0_data", 64'(m_tdata), 64'hE000_0000);
        tick(); s_tdata = 32'hE000_0002; rst = 1'b1;
        smp();
        tick(); rst = 1'b0; s_tvalid = 1'b0;
        smp();  chk("t5_rst_valid", 64'(m_tvalid), 64'(0));
                chk("t5_rst_busy", 64'(busy), 64'(0));
                chk("t5_rst_req_ready", 64'(req_ready), 64'(1));
                chk("t5_rst_s_tready", 64'(s_tready), 64'(0));
                chk("t5_rst_tdata", 64'(m_tdata), 64'(0));
        tick(); req_valid = 1'b1; req_dest_x = 2'd0; req_dest_y = 2'd1; req_len = 3'd1;
        smp();
        tick(); req_valid = 1'b0; s_tvalid = 1'b1; s_tdata = 32'h77;
        smp();  chk("t5_new_hdr", 64'(m_tdata), 64'h194);
        tick(); s_tvalid = 1'b0;
        smp();  chk("t5_new_p0", 64'(m_tdata), 64'h77);
                chk("t5_new_last", 64'(m_tlast), 64'(1));
        tick();
        smp();  chk("t5_new_idle", 64'(m_tvalid), 64'(0));
        exp_q.push_back({1'b0, 32'h59F});
        exp_q.push_back({1'b0, 32'hE000_0000});
        exp_q.push_back({1'b0, 32'h194});
        exp_q.push_back({1'b1, 32'h77});
        cmp_queues("t5_flits");

        // Random stress: random payload gaps and router stalls
        tick();
        rnd_en = 1'b1;
        for (int p = 0; p < 1000; p++) begin
            dx  = 2'($urandom_range(0, 3));
            dy  = 2'($urandom_range(0, 3));
            len = 3'($urandom_range(0, 5));
            req_valid = 1'b1; req_dest_x = dx; req_dest_y = dy; req_len = len;
            exp_q.push_back({(len == 3'd0), hdr(dx, dy, len)});
            acc = 1'b0;
            for (int c = 0; c < 200 && !acc; c++) begin
                smp();
                acc = req_ready;
                tick();
            end
            req_valid = 1'b0;
            if (!acc) chk("stress_req_timeout", 64'(acc), 64'(1));
            for (int b = 0; b < int'(len); b++) begin
                word = $urandom;
                acc  = 1'b0;
                for (int c = 0; c < 200 && !acc; c++) begin
                    s_tvalid = ($urandom_range(0, 3) != 0);
                    s_tdata  = word;
                    smp();
                    acc = s_tvalid && s_tready;
                    tick();
                end
                s_tvalid = 1'b0;
                if (acc) exp_q.push_back({(b == int'(len) - 1), word});
                else chk("stress_beat_timeout", 64'(acc), 64'(1));
            end
        end
        rnd_en = 1'b0;
        m_tready_dir = 1'b1;
        drain("stress");
        cmp_queues("stress_flits");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
